leve1_ifetch: RTL and testbench

LEVE1_IFETCH -- requirements
Module: leve1_ifetch

---
 rtl/leve1_ifetch.sv | 140 ++++++++++++++
 tb/tb_leve1_ifetch.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/leve1_ifetch.sv
// Level-1 instruction fetch: PC register, 2-entry fetch queue, in-order
// response matching and redirect handling with late-response dropping.
// Optional build macro IFETCH_ALIGN_CHK_EN adds the IF_FAULT port and stops
// fetching after a misaligned redirect; without it redirect targets are
// forced to word alignment.
module leve1_ifetch #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned     DEPTH    = 2
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            REDIRECT,
   input  logic [XLEN-1:0] REDIRECT_PC,
   output logic            IMEM_REQ,
   output logic [XLEN-1:0] IMEM_ADDR,
   input  logic            IMEM_GNT,
   input  logic            IMEM_RVALID,
   input  logic [31:0]     IMEM_RDATA,
   output logic            IF_VALID,
   input  logic            IF_READY,
   output logic [XLEN-1:0] IF_PC,
   output logic [31:0]     IF_INSTR,
`ifdef IFETCH_ALIGN_CHK_EN
   output logic            IFLASH,
   output logic            IF_FAULT
`else
   output logic            IFLASH
`endif
);

   localparam int unsigned CW = 2;   // count width for 0..DEPTH
   localparam int unsigned OW = 3;   // occupancy arithmetic width

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] ent_pc    [2];
   logic [31:0]     ent_instr [2];
   logic            hd;              // head entry index
   logic [CW-1:0]   cnt;             // allocated entries
   logic [CW-1:0]   nf;              // filled entries (prefix from head)
   logic [CW-1:0]   drop;            // responses still owed to dropped requests

   logic            stall;
   logic            if_valid_c;
   logic            xfer;
   logic            req_c;
   logic            alloc;
   logic            fill;
   logic            alloc_idx;
   logic            fill_idx;
   logic [OW-1:0]   occ;
   logic [CW-1:0]   unfilled;
   logic [OW-1:0]   drop_sum;
   logic [OW-1:0]   drop_red;
   logic [CW-1:0]   drop_nxt;
   logic [XLEN-1:0] tgt;

`ifdef IFETCH_ALIGN_CHK_EN
   logic fault;
   assign stall = fault;
   assign tgt   = REDIRECT_PC;
`else
   assign stall = 1'b0;
   assign tgt   = REDIRECT_PC & ~XLEN'(3);
`endif

   // Handshakes, occupancy and redirect drop accounting
   always_comb begin
      if_valid_c = 1'b0;
      xfer       = 1'b0;
      req_c      = 1'b0;
      alloc      = 1'b0;
      fill       = 1'b0;
      if_valid_c = !RST && !REDIRECT && (nf != '0);
      xfer       = if_valid_c && IF_READY;
      occ        = OW'(drop) + OW'(cnt) - OW'(xfer);
      req_c      = !RST && !REDIRECT && !stall && (occ < OW'(DEPTH));
      alloc      = req_c && IMEM_GNT;
      fill       = IMEM_RVALID && (drop == '0) && (nf < cnt);
      alloc_idx  = hd ^ cnt[0];
      fill_idx   = hd ^ nf[0];
      unfilled   = cnt - nf;
      drop_sum   = OW'(drop) + OW'(unfilled);
      drop_red   = (IMEM_RVALID && (drop_sum != '0)) ? drop_sum - OW'(1) : drop_sum;
      drop_nxt   = (drop_red > OW'(DEPTH)) ? CW'(DEPTH) : drop_red[CW-1:0];
   end

   // PC register, queue pointers/counters and drop counter
   always_ff @(posedge CLK) begin
      if (RST) begin
         pc_q <= RESET_PC;
         hd   <= 1'b0;
         cnt  <= '0;
         nf   <= '0;
         drop <= '0;
      end else if (REDIRECT) begin
         pc_q <= tgt;
         cnt  <= '0;
         nf   <= '0;
         drop <= drop_nxt;
      end else begin
         if (alloc) pc_q <= pc_q + XLEN'(4);
         hd  <= hd ^ xfer;
         cnt <= cnt + CW'(alloc) - CW'(xfer);
         nf  <= nf + CW'(fill) - CW'(xfer);
         if (IMEM_RVALID && (drop != '0)) drop <= drop - CW'(1);
      end
   end

   // Queue payload: PC on grant, instruction on matched response
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < 2; i++) begin
            ent_pc[i]    <= '0;
            ent_instr[i] <= '0;
         end
      end else if (!REDIRECT) begin
         if (alloc) ent_pc[alloc_idx]   <= pc_q;
         if (fill)  ent_instr[fill_idx] <= IMEM_RDATA;
      end
   end

`ifdef IFETCH_ALIGN_CHK_EN
   // Misaligned redirect raises the fault; an aligned one clears it
   always_ff @(posedge CLK) begin
      if (RST)           fault <= 1'b0;
      else if (REDIRECT) fault <= (REDIRECT_PC[1:0] != 2'b00);
   end

   assign IF_FAULT = fault && !RST;
`endif

   assign IMEM_REQ  = req_c;
   assign IMEM_ADDR = pc_q;
   assign IF_VALID  = if_valid_c;
   assign IF_PC     = RST ? '0 : ent_pc[hd];
   assign IF_INSTR  = RST ? '0 : ent_instr[hd];
   assign IFLASH    = REDIRECT;

endmodule

// File: tb/tb_leve1_ifetch.sv
// Bench for leve1_ifetch: scripted cycle table, corner sequences, then
// randomized traffic against a transaction-level fetch/memory model.
module tb_leve1_ifetch;

   localparam logic [31:0] RST_PC = 32'h0;

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        iflash;
`ifdef IFETCH_ALIGN_CHK_EN
   logic        if_fault;
`endif

   int total = 0;
   int bad   = 0;

   leve1_ifetch #(.XLEN(32), .RESET_PC(RST_PC), .DEPTH(2)) dut (
      .CLK(clk), .RST(rst), .REDIRECT(redirect), .REDIRECT_PC(redirect_pc),
      .IMEM_REQ(imem_req), .IMEM_ADDR(imem_addr), .IMEM_GNT(imem_gnt),
      .IMEM_RVALID(imem_rvalid), .IMEM_RDATA(imem_rdata),
      .IF_VALID(if_valid), .IF_READY(if_ready), .IF_PC(if_pc),
      .IF_INSTR(if_instr),
`ifdef IFETCH_ALIGN_CHK_EN
      .IFLASH(iflash), .IF_FAULT(if_fault)
`else
      .IFLASH(iflash)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        gnt;
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      logic        rd;
      logic [31:0] tgt;
      logic        req;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] ifpc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic gnt, input logic rv, input logic [31:0] rpc,
                               input logic rdy, input logic rd, input logic [31:0] tgt,
                               input logic req, input logic [31:0] addr,
                               input logic vld, input logic [31:0] ifpc);
      vec_t v;
      v.gnt = gnt; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.rd = rd; v.tgt = tgt;
      v.req = req; v.addr = addr; v.vld = vld; v.ifpc = ifpc;
      return v;
   endfunction

   task automatic do_reset(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         rst         = 1'b1;
         redirect    = (k % 2) == 1;
         redirect_pc = $urandom;
         imem_gnt    = 1'b1;
         imem_rvalid = 1'b0;
         if_ready    = 1'b1;
         #3;
         chk($sformatf("rst%0d_req", k), 32'(imem_req), 32'd0);
         chk($sformatf("rst%0d_vld", k), 32'(if_valid), 32'd0);
         chk($sformatf("rst%0d_pc", k), if_pc, 32'd0);
         chk($sformatf("rst%0d_instr", k), if_instr, 32'd0);
         chk($sformatf("rst%0d_flash", k), 32'(iflash), 32'(redirect));
`ifdef IFETCH_ALIGN_CHK_EN
         chk($sformatf("rst%0d_fault", k), 32'(if_fault), 32'd0);
`endif
      end
   endtask

   task automatic drive(input logic gnt, input logic rv, input logic [31:0] rdata,
                        input logic rdy, input logic rd, input logic [31:0] tgt);
      @(posedge clk); #1;
      rst         = 1'b0;
      imem_gnt    = gnt;
      imem_rvalid = rv;
      imem_rdata  = rdata;
      if_ready    = rdy;
      redirect    = rd;
      redirect_pc = tgt;
      #3;
   endtask

   // Random-phase model state
   logic [31:0] mq_addr[$];
   int          mq_ep[$];
   logic [31:0] fetch_pc, exp_pc;
   int          live, filled, epoch, stale, delivered;
   logic        rv, exp_vld, exp_req, xfer;

   initial begin
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
      imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;

      //             gnt rv rpc           rdy rd tgt           req addr          vld ifpc
      tbl.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h0,        0, 32'h0));
      tbl.push_back(mk(1, 1, 32'h0,        1, 0, 32'h0,        1, 32'h4,        0, 32'h0));
      tbl.push_back(mk(1, 1, 32'h4,        1, 0, 32'h0,        1, 32'h8,        1, 32'h0));
      tbl.push_back(mk(1, 1, 32'h8,        1, 0, 32'h0,        1, 32'hC,        1, 32'h4));
      tbl.push_back(mk(1, 1, 32'hC,        1, 0, 32'h0,        1, 32'h10,       1, 32'h8));
      tbl.push_back(mk(1, 1, 32'h10,       0, 0, 32'h0,        0, 32'h14,       1, 32'hC));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(1, 0, 32'h0,     0, 0, 32'h0,        0, 32'h14,       1, 32'hC));
      tbl.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h14,       1, 32'hC));
      tbl.push_back(mk(1, 1, 32'h14,       1, 0, 32'h0,        1, 32'h18,       1, 32'h10));
      tbl.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h1C,       1, 32'h14));
      tbl.push_back(mk(1, 0, 32'h0,        1, 1, 32'h100,      0, 32'h20,       0, 32'h0));
      tbl.push_back(mk(1, 1, 32'h18,       1, 0, 32'h0,        0, 32'h100,      0, 32'h0));
      tbl.push_back(mk(1, 1, 32'h1C,       1, 0, 32'h0,        1, 32'h100,      0, 32'h0));
      tbl.push_back(mk(1, 1, 32'h100,      1, 0, 32'h0,        1, 32'h104,      0, 32'h0));
      tbl.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h108,      1, 32'h100));
      tbl.push_back(mk(1, 1, 32'h104,      1, 1, 32'h40,       0, 32'h10C,      0, 32'h0));
      tbl.push_back(mk(1, 1, 32'h108,      1, 0, 32'h0,        1, 32'h40,       0, 32'h0));
      tbl.push_back(mk(0, 1, 32'h40,       1, 0, 32'h0,        1, 32'h44,       0, 32'h0));
      tbl.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h44,       1, 32'h40));
      tbl.push_back(mk(0, 0, 32'h0,        1, 1, 32'hFFFF_FFFC, 0, 32'h44,      0, 32'h0));
      tbl.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h0));
      tbl.push_back(mk(0, 1, 32'hFFFF_FFFC, 1, 0, 32'h0,       1, 32'h0,        0, 32'h0));
      tbl.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h0,        1, 32'hFFFF_FFFC));
      tbl.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h0,        0, 32'h0));
      tbl.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h4,        0, 32'h0));
      tbl.push_back(mk(0, 0, 32'h0,        1, 1, 32'h300,      0, 32'h8,        0, 32'h0));
      tbl.push_back(mk(0, 1, 32'h0,        1, 1, 32'h400,      0, 32'h300,      0, 32'h0));
      tbl.push_back(mk(1, 1, 32'h4,        1, 0, 32'h0,        1, 32'h400,      0, 32'h0));
      tbl.push_back(mk(0, 1, 32'h400,      1, 0, 32'h0,        1, 32'h404,      0, 32'h0));
      tbl.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h404,      1, 32'h400));

      do_reset(3);

      // Scripted cycles straight out of reset
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].gnt, tbl[i].rv, tbl[i].rv ? instr_of(tbl[i].rpc) : $urandom,
               tbl[i].rdy, tbl[i].rd, tbl[i].tgt);
         chk($sformatf("row%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
         chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].addr);
         chk($sformatf("row%0d_vld", i), 32'(if_valid), 32'(tbl[i].vld));
         chk($sformatf("row%0d_flash", i), 32'(iflash), 32'(tbl[i].rd));
         if (tbl[i].vld) begin
            chk($sformatf("row%0d_pc", i), if_pc, tbl[i].ifpc);
            chk($sformatf("row%0d_instr", i), if_instr, instr_of(tbl[i].ifpc));
         end
      end

      // Misaligned redirect target
      drive(0, 0, 32'h0, 1, 1, 32'h102);
      chk("mis_req", 32'(imem_req), 32'd0);
`ifdef IFETCH_ALIGN_CHK_EN
      for (int k = 0; k < 2; k++) begin
         drive(1, 0, 32'h0, 1, 0, 32'h0);
         chk($sformatf("mis_fault%0d", k), 32'(if_fault), 32'd1);
         chk($sformatf("mis_stall%0d", k), 32'(imem_req), 32'd0);
      end
      drive(1, 0, 32'h0, 1, 1, 32'h200);
      chk("fix_req", 32'(imem_req), 32'd0);
      drive(1, 0, 32'h0, 1, 0, 32'h0);
      chk("fix_fault", 32'(if_fault), 32'd0);
      chk("fix_req1", 32'(imem_req), 32'd1);
      chk("fix_addr", imem_addr, 32'h200);
      drive(0, 0, 32'h0, 1, 0, 32'h0);
      chk("fix_next", imem_addr, 32'h204);
`else
      drive(0, 0, 32'h0, 1, 0, 32'h0);
      chk("mis_req1", 32'(imem_req), 32'd1);
      chk("mis_addr", imem_addr, 32'h100);
`endif

      // Requests in flight when reset hits are simply abandoned
      for (int k = 0; k < 3; k++) drive(1, 0, 32'h0, 0, 0, 32'h0);
      do_reset(2);

      // Randomized traffic against the transaction model
      fetch_pc = RST_PC; exp_pc = RST_PC;
      live = 0; filled = 0; epoch = 0; delivered = 0;
      mq_addr.delete(); mq_ep.delete();
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk); #1;
         rst         = 1'b0;
         imem_gnt    = ($urandom_range(0, 3) != 0);
         if_ready    = ($urandom_range(0, 3) != 0);
         rv          = (mq_addr.size() != 0) && ($urandom_range(0, 2) != 0);
         imem_rvalid = rv;
         imem_rdata  = rv ? instr_of(mq_addr[0]) : $urandom;
         redirect    = ($urandom_range(0, 15) == 0);
         redirect_pc = $urandom;
`ifdef IFETCH_ALIGN_CHK_EN
         redirect_pc[1:0] = 2'b00;
`endif
         #3;
         stale = 0;
         for (int i = 0; i < mq_ep.size(); i++) if (mq_ep[i] != epoch) stale++;
         exp_vld = !redirect && (filled > 0);
         xfer    = exp_vld && if_ready;
         exp_req = !redirect && ((live + stale - (xfer ? 1 : 0)) < 2);
         chk("rnd_vld", 32'(if_valid), 32'(exp_vld));
         chk("rnd_req", 32'(imem_req), 32'(exp_req));
         chk("rnd_flash", 32'(iflash), 32'(redirect));
         if (exp_vld) begin
            chk("rnd_pc", if_pc, exp_pc);
            chk("rnd_instr", if_instr, instr_of(exp_pc));
         end
         if (exp_req) chk("rnd_addr", imem_addr, fetch_pc);

         // Advance the model across the clock edge
         if (rv) begin
            if (!redirect && mq_ep[0] == epoch) filled++;
            void'(mq_addr.pop_front());
            void'(mq_ep.pop_front());
         end
         if (redirect) begin
            epoch++;
            live     = 0;
            filled   = 0;
            fetch_pc = redirect_pc & ~32'd3;
            exp_pc   = fetch_pc;
         end else begin
            if (xfer) begin
               live--; filled--; delivered++;
               exp_pc = exp_pc + 32'd4;
            end
            if (exp_req && imem_gnt) begin
               mq_addr.push_back(fetch_pc);
               mq_ep.push_back(epoch);
               live++;
               fetch_pc = fetch_pc + 32'd4;
            end
         end
      end
      chk("deliveries", 32'(delivered >= 200), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
